rr_port_arbiter: RTL and testbench

//  Parametrised round-robin arbiter for one router output port; replaces the per-direction rr processors.

---
 rtl/noc_arb_pkg.sv | 17 +
 rtl/rr_pick.sv | 42 ++++
 rtl/rr_port_arbiter.sv | 121 ++++++++++++
 tb/tb_rr_port_arbiter.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/noc_arb_pkg.sv
// Shared port codes, default address width and arbiter FSM states for the NoC router.
package noc_arb_pkg;

    localparam int PORT_N = 0;
    localparam int PORT_S = 1;
    localparam int PORT_W = 2;
    localparam int PORT_E = 3;
    localparam int PORT_L = 4;

    localparam int NOC_ADDR_W = 3;

    typedef enum logic {
        ARB_IDLE,
        ARB_LOCKED
    } arb_state_e;

endpackage

// File: rtl/rr_pick.sv
// Round-robin pick: first set request at or after ptr, wrapping modulo NUM_IN.
// Latency: combinational. Backpressure: none, pure function of req/ptr.
module rr_pick #(
    parameter int NUM_IN = 5,
    parameter int IDX_W  = $clog2(NUM_IN)
) (
    input  logic [NUM_IN-1:0] req,
    input  logic [IDX_W-1:0]  ptr,
    output logic [NUM_IN-1:0] onehot,
    output logic [IDX_W-1:0]  idx,
    output logic              any
);

    logic [2*NUM_IN-1:0] req_dbl;
    logic [2*NUM_IN-1:0] rot_dbl;
    logic [NUM_IN-1:0]   rot;
    logic                found;
    int                  pos;

    // Doubling the vector turns the rotate into a plain shift; bit k of rot is req[(ptr+k) mod NUM_IN].
    assign req_dbl = {req, req};
    assign rot_dbl = req_dbl >> ptr;
    assign rot     = rot_dbl[NUM_IN-1:0];
    assign any     = |req;

    always_comb begin
        onehot = '0;
        idx    = '0;
        found  = 1'b0;
        pos    = 0;
        for (int k = 0; k < NUM_IN; k++) begin
            if (!found && rot[k]) begin
                found  = 1'b1;
                pos    = int'(ptr) + k;
                if (pos >= NUM_IN) pos = pos - NUM_IN;
                idx    = IDX_W'(pos);
                onehot = NUM_IN'(1) << pos;
            end
        end
    end

endmodule

// File: rtl/rr_port_arbiter.sv
// Round-robin output-port arbiter: locks the port to one input from head until its tail is accepted.
// Latency: 1 cycle request->grant; tail re-arbitration in the same cycle, so back-to-back packets see no bubble.
// Backpressure: out_ready_i low stalls the locked winner; grant and pointer hold, other requests wait.
module rr_port_arbiter
    import noc_arb_pkg::*;
#(
    parameter int NUM_IN      = 5,
    parameter int ADDR_W      = NOC_ADDR_W,
    parameter int PORT_ID     = PORT_N,
    parameter int ALLOW_UTURN = 0,
    parameter int IDX_W       = $clog2(NUM_IN)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_IN*ADDR_W-1:0] nexthop_addr_i,
    input  logic [NUM_IN-1:0]        flit_valid_i,
    input  logic [NUM_IN-1:0]        flit_tail_i,
    input  logic                     out_ready_i,
    output logic [NUM_IN-1:0]        grant_o,
    output logic [IDX_W-1:0]         grant_idx_o,
    output logic                     grant_valid_o,
    output logic                     flit_fire_o,
    output logic [IDX_W-1:0]         priority_ptr_o
);

    arb_state_e        state_q, state_d;
    logic [NUM_IN-1:0] grant_q, grant_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [IDX_W-1:0]  ptr_q, ptr_d;

    logic [NUM_IN-1:0] req;
    logic [NUM_IN-1:0] pick_onehot;
    logic [IDX_W-1:0]  pick_idx;
    logic              pick_any;
    logic [IDX_W-1:0]  pick_ptr;
    logic [IDX_W-1:0]  ptr_after;
    logic              locked;
    logic              fire;
    logic              tail_fire;

    // Addresses >= NUM_IN can never equal PORT_ID, so out-of-range codes raise no request.
    always_comb begin
        req = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            req[i] = flit_valid_i[i]
                   && (nexthop_addr_i[i*ADDR_W +: ADDR_W] == ADDR_W'(PORT_ID))
                   && ((ALLOW_UTURN != 0) || (i != PORT_ID));
        end
    end

    assign locked    = (state_q == ARB_LOCKED);
    assign fire      = locked && flit_valid_i[idx_q] && out_ready_i;
    assign tail_fire = fire && flit_tail_i[idx_q];
    assign ptr_after = (idx_q == IDX_W'(NUM_IN - 1)) ? '0 : idx_q + IDX_W'(1);
    assign pick_ptr  = tail_fire ? ptr_after : ptr_q;

    rr_pick #(
        .NUM_IN (NUM_IN),
        .IDX_W  (IDX_W)
    ) u_pick (
        .req    (req),
        .ptr    (pick_ptr),
        .onehot (pick_onehot),
        .idx    (pick_idx),
        .any    (pick_any)
    );

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        idx_d   = idx_q;
        ptr_d   = ptr_q;
        case (state_q)
            ARB_IDLE: begin
                if (pick_any) begin
                    state_d = ARB_LOCKED;
                    grant_d = pick_onehot;
                    idx_d   = pick_idx;
                end
            end
            ARB_LOCKED: begin
                // Only a tail transfer releases the lock; the winner becomes lowest priority.
                if (tail_fire) begin
                    ptr_d = ptr_after;
                    if (pick_any) begin
                        grant_d = pick_onehot;
                        idx_d   = pick_idx;
                    end else begin
                        state_d = ARB_IDLE;
                        grant_d = '0;
                    end
                end
            end
            default: begin
                state_d = ARB_IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ARB_IDLE;
            grant_q <= '0;
            idx_q   <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            idx_q   <= idx_d;
            ptr_q   <= ptr_d;
        end
    end

    assign grant_o        = grant_q;
    assign grant_idx_o    = idx_q;
    assign grant_valid_o  = locked;
    assign flit_fire_o    = fire;
    assign priority_ptr_o = ptr_q;

endmodule

// File: tb/tb_rr_port_arbiter.sv
// Directed bench for rr_port_arbiter: NUM_IN=5, PORT_ID=0, plus a U-turn-enabled instance on the same inputs.
module tb_rr_port_arbiter;

    localparam int NUM_IN = 5;
    localparam int ADDR_W = 3;
    localparam int IDX_W  = 3;

    logic                     clk;
    logic                     reset;
    logic [NUM_IN*ADDR_W-1:0] nh;
    logic [NUM_IN-1:0]        vld;
    logic [NUM_IN-1:0]        tail;
    logic                     rdy;

    logic [NUM_IN-1:0] grant,   grant_ut;
    logic [IDX_W-1:0]  idx,     idx_ut;
    logic              gvld,    gvld_ut;
    logic              fire,    fire_ut;
    logic [IDX_W-1:0]  ptr,     ptr_ut;

    int tests = 0;
    int fails = 0;
    int nfire = 0;
    int exp_seq [6] = '{1, 2, 4, 1, 2, 4};

    rr_port_arbiter #(
        .NUM_IN(NUM_IN), .ADDR_W(ADDR_W), .PORT_ID(0), .ALLOW_UTURN(0)
    ) u_dut (
        .clk(clk), .reset(reset), .nexthop_addr_i(nh), .flit_valid_i(vld),
        .flit_tail_i(tail), .out_ready_i(rdy), .grant_o(grant), .grant_idx_o(idx),
        .grant_valid_o(gvld), .flit_fire_o(fire), .priority_ptr_o(ptr)
    );

    rr_port_arbiter #(
        .NUM_IN(NUM_IN), .ADDR_W(ADDR_W), .PORT_ID(0), .ALLOW_UTURN(1)
    ) u_dut_ut (
        .clk(clk), .reset(reset), .nexthop_addr_i(nh), .flit_valid_i(vld),
        .flit_tail_i(tail), .out_ready_i(rdy), .grant_o(grant_ut), .grant_idx_o(idx_ut),
        .grant_valid_o(gvld_ut), .flit_fire_o(fire_ut), .priority_ptr_o(ptr_ut)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (observed timeout, expected completion)");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input int i, input logic [ADDR_W-1:0] a, input logic v, input logic t);
        nh[i*ADDR_W +: ADDR_W] = a;
        vld[i]  = v;
        tail[i] = t;
    endtask

    task automatic clr_all();
        nh   = '1;
        vld  = '0;
        tail = '0;
    endtask

    initial begin
        // Reset held while every input requests this port
        reset = 1'b0;
        rdy   = 1'b1;
        nh    = '0;
        vld   = '1;
        tail  = '1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_grant", grant, 0);
        chk("rst_idx",   idx,   0);
        chk("rst_valid", gvld,  0);
        chk("rst_fire",  fire,  0);
        chk("rst_ptr",   ptr,   0);
        reset = 1'b1;
        tick();
        chk("rel_valid", gvld,  1);
        chk("rel_idx",   idx,   1);
        chk("rel_grant", grant, 5'b00010);
        chk("rel_idx_ut", idx_ut, 0);
        reset = 1'b0;
        #1;
        chk("rst2_valid", gvld, 0);
        clr_all();
        #1;
        reset = 1'b1;

        // Fairness: 1,2,4 stream single-flit packets
        set_in(1, 0, 1, 1);
        set_in(2, 0, 1, 1);
        set_in(4, 0, 1, 1);
        for (int k = 0; k < 6; k++) begin
            tick();
            chk("fair_idx",   idx,   exp_seq[k]);
            chk("fair_fire",  fire,  1);
            chk("fair_grant", grant, 1 << exp_seq[k]);
        end
        chk("fair_ptr", ptr, 3);
        clr_all();
        set_in(4, 7, 1, 1);
        #1;
        chk("fair_last_fire", fire, 1);
        tick();
        chk("fair_end_valid", gvld,  0);
        chk("fair_end_grant", grant, 0);
        chk("fair_end_ptr",   ptr,   0);

        // Lock: 4-flit packet from input 3 with a stall, input 1 waiting
        clr_all();
        set_in(3, 0, 1, 0);
        tick();
        set_in(1, 0, 1, 1);
        #1;
        chk("lock_idx_f1", idx, 3);
        nfire += int'(fire);
        tick();
        rdy = 1'b0;
        #1;
        chk("lock_idx_stall",  idx,  3);
        chk("lock_fire_stall", fire, 0);
        nfire += int'(fire);
        tick();
        rdy = 1'b1;
        #1;
        chk("lock_idx_f2", idx, 3);
        nfire += int'(fire);
        tick();
        nfire += int'(fire);
        tick();
        set_in(3, 0, 1, 1);
        #1;
        chk("lock_idx_f4",  idx, 3);
        chk("lock_ptr_pre", ptr, 0);
        nfire += int'(fire);
        tick();
        set_in(3, 7, 0, 0);
        set_in(1, 7, 1, 1);
        #1;
        chk("lock_nfire", nfire, 4);
        chk("lock_next",  idx,   1);
        chk("lock_ptr",   ptr,   4);
        chk("lock_fire1", fire,  1);
        tick();
        chk("lock_end_valid", gvld, 0);
        chk("lock_end_ptr",   ptr,  2);

        // Wrap: drive ptr to 4, then tail from input 4 wraps ptr to 0
        clr_all();
        set_in(3, 0, 1, 1);
        tick();
        chk("wrap_idx3", idx, 3);
        set_in(3, 7, 1, 1);
        tick();
        set_in(3, 7, 0, 0);
        chk("wrap_ptr4",  ptr,  4);
        chk("wrap_idle",  gvld, 0);
        set_in(4, 0, 1, 1);
        set_in(1, 0, 1, 1);
        tick();
        chk("wrap_idx4", idx, 4);
        set_in(4, 7, 1, 1);
        tick();
        chk("wrap_ptr0",  ptr,   0);
        chk("wrap_idx1",  idx,   1);
        chk("wrap_grant", grant, 5'b00010);
        set_in(4, 7, 0, 0);
        set_in(1, 7, 1, 1);
        tick();
        set_in(1, 7, 0, 0);
        chk("wrap_end_valid", gvld, 0);
        chk("wrap_end_ptr",   ptr,  2);

        // Masking: input 0 requesting its own port
        set_in(0, 0, 1, 1);
        tick();
        chk("mask_valid",    gvld,     0);
        chk("mask_grant",    grant,    0);
        chk("mask_fire",     fire,     0);
        chk("uturn_valid",   gvld_ut,  1);
        chk("uturn_idx",     idx_ut,   0);
        chk("uturn_grant",   grant_ut, 5'b00001);
        set_in(0, 7, 1, 1);
        tick();
        set_in(0, 7, 0, 0);
        chk("uturn_end_valid", gvld_ut, 0);
        chk("uturn_end_ptr",   ptr_ut,  1);
        chk("mask_end_ptr",    ptr,     2);

        // Async reset between head and tail
        set_in(2, 0, 1, 0);
        tick();
        chk("mid_idx",  idx,  2);
        chk("mid_fire", fire, 1);
        tick();
        reset = 1'b0;
        #1;
        chk("mid_rst_valid", gvld,  0);
        chk("mid_rst_grant", grant, 0);
        chk("mid_rst_idx",   idx,   0);
        chk("mid_rst_ptr",   ptr,   0);
        chk("mid_rst_fire",  fire,  0);
        clr_all();
        set_in(1, 0, 1, 1);
        set_in(3, 0, 1, 1);
        #1;
        reset = 1'b1;
        tick();
        chk("restart_idx", idx, 1);
        chk("restart_ptr", ptr, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
